motoro3_commutator: RTL and testbench

Parametrised six-step three-phase commutation sequencer, successor to the fixed 17-bit motor state machine. It drives the per-phase enable/high-side bits of the 3-phase bridge driver and adds:
- configurable counter and frequency widths
- forward/reverse rotation
- a soft-start period ramp from a start period down to a target period
- an explicit stop command
- optional dead time between steps

It sits between the host control registers and the gate-drive output stage.

---
 rtl/motoro3_pkg.sv | 53 +++++
 rtl/motoro3_commutator_if.sv | 31 +++
 rtl/motoro3_commutation_decode.sv | 35 +++
 rtl/motoro3_commutator.sv | 133 +++++++++++++
 tb/tb_motoro3_commutator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/motoro3_pkg.sv
// motoro3_pkg: step encodings, six-step commutation table and step sequencing
// shared by motoro3_commutator and motoro3_commutation_decode.
package motoro3_pkg;

    typedef enum logic [2:0] {
        STEP_IDLE = 3'd0,
        STEP_1    = 3'd1,
        STEP_2    = 3'd2,
        STEP_3    = 3'd3,
        STEP_4    = 3'd4,
        STEP_5    = 3'd5,
        STEP_6    = 3'd6,
        STEP_STOP = 3'd7
    } step_e;

    // {aE, bE, cE, aH1_L0, bH1_L0, cH1_L0}; index 0 holds step 1
    localparam logic [5:0] PHASE_TBL [6] = '{
        6'b110_100,
        6'b101_100,
        6'b011_010,
        6'b110_010,
        6'b101_001,
        6'b011_001
    };

    function automatic step_e next_step(input step_e s, input logic dir);
        step_e n;
        n = s;
        if (dir) begin
            case (s)
                STEP_1:  n = STEP_6;
                STEP_2:  n = STEP_1;
                STEP_3:  n = STEP_2;
                STEP_4:  n = STEP_3;
                STEP_5:  n = STEP_4;
                STEP_6:  n = STEP_5;
                default: n = s;
            endcase
        end else begin
            case (s)
                STEP_1:  n = STEP_2;
                STEP_2:  n = STEP_3;
                STEP_3:  n = STEP_4;
                STEP_4:  n = STEP_5;
                STEP_5:  n = STEP_6;
                STEP_6:  n = STEP_1;
                default: n = s;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/motoro3_commutator_if.sv
// motoro3_commutator_if: host control / gate-drive signal bundle of the commutator.
// master = host register side, slave = commutator.
interface motoro3_commutator_if #(
    parameter int CNT_W  = 17,
    parameter int FREQ_W = 10
);
    logic              m3start;
    logic              m3stop;
    logic              m3dir;
    logic [FREQ_W-1:0] m3freq_start;
    logic [FREQ_W-1:0] m3freq;
    logic              aE, bE, cE;
    logic              aH1_L0, bH1_L0, cH1_L0;
    logic [2:0]        m3step;
    logic [CNT_W-1:0]  m3cnt;
    logic [FREQ_W-1:0] m3per;
    logic              m3busy;
    logic              m3dead;

    modport master (
        output m3start, m3stop, m3dir, m3freq_start, m3freq,
        input  aE, bE, cE, aH1_L0, bH1_L0, cH1_L0,
        input  m3step, m3cnt, m3per, m3busy, m3dead
    );

    modport slave (
        input  m3start, m3stop, m3dir, m3freq_start, m3freq,
        output aE, bE, cE, aH1_L0, bH1_L0, cH1_L0,
        output m3step, m3cnt, m3per, m3busy, m3dead
    );
endinterface

// File: rtl/motoro3_commutation_decode.sv
// motoro3_commutation_decode: combinational step/dead-time to phase enable and
// high/low-side decode for the 3-phase bridge.
module motoro3_commutation_decode
    import motoro3_pkg::*;
(
    input  step_e step,
    input  logic  dead,
    output logic  aE,
    output logic  bE,
    output logic  cE,
    output logic  aH1_L0,
    output logic  bH1_L0,
    output logic  cH1_L0
);

    logic [5:0] phase;

    always_comb begin
        phase = '0;
        if (!dead) begin
            case (step)
                STEP_1:  phase = PHASE_TBL[0];
                STEP_2:  phase = PHASE_TBL[1];
                STEP_3:  phase = PHASE_TBL[2];
                STEP_4:  phase = PHASE_TBL[3];
                STEP_5:  phase = PHASE_TBL[4];
                STEP_6:  phase = PHASE_TBL[5];
                default: phase = '0;
            endcase
        end
    end

    assign {aE, bE, cE, aH1_L0, bH1_L0, cH1_L0} = phase;

endmodule

// File: rtl/motoro3_commutator.sv
// motoro3_commutator: six-step three-phase commutation sequencer with direction,
// soft-start period ramp and stop. Define MOTORO3_DEADTIME_EN to insert dead time.
module motoro3_commutator
    import motoro3_pkg::*;
#(
    parameter int CNT_W    = 17,
    parameter int FREQ_W   = 10,
    parameter int SHIFT    = 6,
    parameter int RAMP_DEC = 1,
    parameter int DEAD_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    motoro3_commutator_if.slave  bus
);

    if (FREQ_W + SHIFT > CNT_W || DEAD_CYC < 1) begin : g_param_check
        $error("motoro3_commutator: FREQ_W+SHIFT must fit CNT_W and DEAD_CYC must be >= 1");
    end

    localparam logic [FREQ_W-1:0] RAMP_STEP = FREQ_W'(RAMP_DEC);

    step_e             step_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FREQ_W-1:0] per_q;
    logic              dead_q;
    logic              start_edge;
    logic              busy;
    logic [FREQ_W-1:0] per_next;

    function automatic logic [CNT_W-1:0] reload(input logic [FREQ_W-1:0] p);
        return CNT_W'(p) << SHIFT;
    endfunction

    assign start_edge = bus.m3start && !start_q && !bus.m3stop && (bus.m3freq != '0);
    assign busy       = (step_q != STEP_IDLE) && (step_q != STEP_STOP);

    // Ramp toward the target, saturating at it rather than stepping past
    always_comb begin
        per_next = bus.m3freq;
        if (per_q > bus.m3freq && (per_q - bus.m3freq) > RAMP_STEP)
            per_next = per_q - RAMP_STEP;
    end

`ifdef MOTORO3_DEADTIME_EN
    localparam int              DC_W      = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEAD_CYC - 1);
    logic [DC_W-1:0] dead_cnt_q;
`else
    assign dead_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            step_q  <= STEP_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
`ifdef MOTORO3_DEADTIME_EN
            dead_q     <= 1'b0;
            dead_cnt_q <= '0;
`endif
        end else begin
            start_q <= bus.m3start;
            if (bus.m3stop) begin
                step_q <= STEP_STOP;
                cnt_q  <= '0;
`ifdef MOTORO3_DEADTIME_EN
                dead_q <= 1'b0;
`endif
            end else if (start_edge) begin
                step_q <= STEP_1;
                per_q  <= bus.m3freq_start;
                cnt_q  <= reload(bus.m3freq_start);
`ifdef MOTORO3_DEADTIME_EN
                dead_q <= 1'b0;
`endif
            end else if (busy) begin
`ifdef MOTORO3_DEADTIME_EN
                // cnt_q stays at 0 through the dead window; the step advances as it closes
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else if (!dead_q) begin
                    dead_q     <= 1'b1;
                    dead_cnt_q <= DEAD_LOAD;
                end else if (dead_cnt_q != '0) begin
                    dead_cnt_q <= dead_cnt_q - DC_W'(1);
                end else begin
                    dead_q <= 1'b0;
                    step_q <= next_step(step_q, bus.m3dir);
                    per_q  <= per_next;
                    cnt_q  <= reload(per_next);
                end
`else
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    step_q <= next_step(step_q, bus.m3dir);
                    per_q  <= per_next;
                    cnt_q  <= reload(per_next);
                end
`endif
            end
        end
    end

    logic a_en, b_en, c_en, a_hi, b_hi, c_hi;

    motoro3_commutation_decode u_decode (
        .step   (step_q),
        .dead   (dead_q),
        .aE     (a_en),
        .bE     (b_en),
        .cE     (c_en),
        .aH1_L0 (a_hi),
        .bH1_L0 (b_hi),
        .cH1_L0 (c_hi)
    );

    assign bus.aE     = a_en;
    assign bus.bE     = b_en;
    assign bus.cE     = c_en;
    assign bus.aH1_L0 = a_hi;
    assign bus.bH1_L0 = b_hi;
    assign bus.cH1_L0 = c_hi;
    assign bus.m3step = step_q;
    assign bus.m3cnt  = cnt_q;
    assign bus.m3per  = per_q;
    assign bus.m3busy = busy;
    assign bus.m3dead = dead_q;

endmodule

// File: tb/tb_motoro3_commutator.sv
// tb_motoro3_commutator: randomized scoreboard bench; a behavioural model predicts
// every step change and a monitor compares them as the DUT presents them.
module tb_motoro3_commutator;

    localparam int CNT_W    = 17;
    localparam int FREQ_W   = 10;
    localparam int SHIFT    = 2;
    localparam int RAMP_DEC = 2;
    localparam int DEAD_CYC = 4;
`ifdef MOTORO3_DEADTIME_EN
    localparam int DT = DEAD_CYC;
`else
    localparam int DT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    motoro3_commutator_if #(.CNT_W(CNT_W), .FREQ_W(FREQ_W)) bus ();

    motoro3_commutator #(
        .CNT_W    (CNT_W),
        .FREQ_W   (FREQ_W),
        .SHIFT    (SHIFT),
        .RAMP_DEC (RAMP_DEC),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int per;    // -1: not checked
        int dwell;  // 0: step is cut short, length not checked
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference rules
    function automatic int nstep(input int s, input bit d);
        return d ? ((s + 4) % 6) + 1 : (s % 6) + 1;
    endfunction

    function automatic int nper(input int p, input int f);
        if (p > f) return (p - RAMP_DEC > f) ? p - RAMP_DEC : f;
        return f;
    endfunction

    function automatic int dwell_of(input int p);
        return p * (1 << SHIFT) + 1 + DT;
    endfunction

    function automatic int eh_of(input int s);
        case (s)
            1:       return 'b110_100;
            2:       return 'b101_100;
            3:       return 'b011_010;
            4:       return 'b110_010;
            5:       return 'b101_001;
            6:       return 'b011_001;
            default: return 0;
        endcase
    endfunction

    function automatic int eh_now();
        return int'({bus.aE, bus.bE, bus.cE, bus.aH1_L0, bus.bH1_L0, bus.cH1_L0});
    endfunction

    initial begin : monitor
        int  prev = 0;
        int  len = 0;
        int  dead_len = 0;
        int  want_dwell = 0;
        bit  run;
        ev_t e;
        forever begin
            @(negedge clk);
            if (bus.m3dead) check("dead_outputs_off", eh_now(), 0);
            if (int'(bus.m3step) != prev) begin
                if (want_dwell != 0) begin
                    check("dwell", len, want_dwell);
                    check("dead_cycles", dead_len, DT);
                end
                want_dwell = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_step", bus.m3step, prev);
                end else begin
                    e   = exp_q.pop_front();
                    run = (e.step >= 1 && e.step <= 6);
                    check("step", bus.m3step, e.step);
                    check("phase_eh", eh_now(), eh_of(e.step));
                    check("busy", bus.m3busy, run);
                    check("cnt", bus.m3cnt, run ? e.per * (1 << SHIFT) : 0);
                    if (e.per >= 0) check("per", bus.m3per, e.per);
                    want_dwell = e.dwell;
                end
                prev     = int'(bus.m3step);
                len      = 1;
                dead_len = int'(bus.m3dead);
            end else begin
                len++;
                dead_len += int'(bus.m3dead);
            end
        end
    end

    // ending: 0 = stop, 1 = next run restarts it, 2 = async reset
    task automatic run(input int fs, input int f, input bit dir0, input int n,
                       input int tog, input int ending);
        int  s, p, acc, t_tog, t_end, mode;
        bit  d;
        ev_t e;
        s = 1; p = fs; d = dir0; acc = 0; t_tog = -1; t_end = 0; mode = ending;
        for (int k = 1; k <= n; k++) begin
            e.step  = s;
            e.per   = p;
            e.dwell = (k < n) ? dwell_of(p) : 0;
            exp_q.push_back(e);
            if (k == tog) begin
                t_tog = acc + dwell_of(p) / 2;
                d = ~d;
            end
            if (k == n) begin
                t_end = acc + dwell_of(p) / 2;
                if (s == 1 && mode == 1) mode = 0;
            end
            acc += dwell_of(p);
            s = nstep(s, d);
            p = nper(p, f);
        end
        bus.m3freq_start = FREQ_W'(fs);
        bus.m3freq       = FREQ_W'(f);
        bus.m3dir        = dir0;
        bus.m3start      = 1'b1;
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            if (t == 1)     bus.m3start = 1'b0;
            if (t == t_tog) bus.m3dir   = ~dir0;
        end
        if (mode == 0) begin
            e.step = 7; e.per = -1; e.dwell = 0;
            exp_q.push_back(e);
            bus.m3stop = 1'b1;
            repeat (3) @(negedge clk);
            bus.m3stop = 1'b0;
            repeat (2) @(negedge clk);
        end else if (mode == 2) begin
            e.step = 0; e.per = 0; e.dwell = 0;
            exp_q.push_back(e);
            #2 rst = 1'b1;
            #1;
            check("async_reset_step", bus.m3step, 0);
            check("async_reset_outputs", eh_now(), 0);
            check("async_reset_cnt", bus.m3cnt, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int fs, f, n, tog, ending;
        bit dir;
        bus.m3start      = 1'b0;
        bus.m3stop       = 1'b0;
        bus.m3dir        = 1'b0;
        bus.m3freq_start = '0;
        bus.m3freq       = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_step", bus.m3step, 0);
        check("reset_cnt", bus.m3cnt, 0);
        check("reset_per", bus.m3per, 0);
        check("reset_busy", bus.m3busy, 0);
        check("reset_dead", bus.m3dead, 0);
        check("reset_outputs", eh_now(), 0);
        rst = 1'b0;
        @(negedge clk);

        bus.m3freq_start = FREQ_W'(3);
        bus.m3freq       = '0;
        bus.m3start      = 1'b1;
        @(negedge clk);
        bus.m3start = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_freq_idle", bus.m3step, 0);
        check("zero_freq_cnt", bus.m3cnt, 0);

        run(3, 3, 1'b0, 7, 0, 0);

        bus.m3freq  = FREQ_W'(3);
        bus.m3stop  = 1'b1;
        bus.m3start = 1'b1;
        repeat (2) @(negedge clk);
        check("stop_beats_start", bus.m3step, 7);
        check("stop_outputs_off", eh_now(), 0);
        bus.m3start = 1'b0;
        bus.m3stop  = 1'b0;
        @(negedge clk);

        run(3, 3, 1'b1, 7, 3, 0);
        run(8, 5, 1'b0, 5, 0, 2);

        for (int i = 0; i < 8; i++) begin
            fs     = int'($urandom_range(1, 12));
            f      = int'($urandom_range(1, 12));
            dir    = 1'($urandom_range(0, 1));
            n      = int'($urandom_range(2, 6));
            tog    = int'($urandom_range(0, n - 1));
            ending = (i == 7) ? 0 : int'($urandom_range(0, 2));
            run(fs, f, dir, n, tog, ending);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
